vdp_vram_arbiter: RTL

//  Shares the single 32-bit VRAM port among four VDP requesters: display (t12/g123m/g4567), sprite, CPU, command engine.

---
 rtl/vdp_vram_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/vdp_vram_arbiter.sv
// rtl/vdp_vram_arbiter.sv - VRAM port arbiter for display, sprite, CPU and command engine
// Fixed priority dsp > spr > (cpu/cmd round-robin); in-order read return through a tag FIFO.
module vdp_vram_arbiter #(
    parameter int TAG_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [16:0] dsp_address,
    input  logic        dsp_valid,
    output logic        dsp_ready,
    output logic [31:0] dsp_rdata,
    output logic        dsp_rdata_en,
    input  logic [16:0] spr_address,
    input  logic        spr_valid,
    output logic        spr_ready,
    output logic [31:0] spr_rdata,
    output logic        spr_rdata_en,
    input  logic [16:0] cpu_address,
    input  logic        cpu_valid,
    input  logic        cpu_write,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ready,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rdata_en,
    input  logic [16:0] cmd_address,
    input  logic        cmd_valid,
    input  logic        cmd_write,
    input  logic [7:0]  cmd_wdata,
    output logic        cmd_ready,
    output logic [31:0] cmd_rdata,
    output logic        cmd_rdata_en,
    output logic [16:0] vram_address,
    output logic        vram_valid,
    output logic        vram_write,
    output logic [31:0] vram_wdata,
    output logic [3:0]  vram_wdata_mask,
    input  logic        vram_ready,
    input  logic [31:0] vram_rdata,
    input  logic        vram_rdata_en,
    output logic        tag_underflow
);
    localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [3:0]    tag_mem [TAG_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] tag_count;
    logic          rr_cmd;

    logic          free_slot;
    logic          read_ok;
    logic          cpu_ok;
    logic          cmd_ok;
    logic [3:0]    grant;
    logic [1:0]    sel_id;
    logic [16:0]   sel_addr;
    logic          sel_write;
    logic [7:0]    sel_wdata;
    logic          push;
    logic          pop;
    logic [3:0]    head;

    always_comb begin
        free_slot = !vram_valid || vram_ready;
        read_ok   = tag_count < CW'(TAG_DEPTH);
        cpu_ok    = cpu_valid && (cpu_write || read_ok);
        cmd_ok    = cmd_valid && (cmd_write || read_ok);
        grant     = 4'b0000;
        if (!reset && free_slot) begin
            // rr_cmd picks which of cpu/cmd is tried first; the other is the fallback
            if (dsp_valid && read_ok)      grant = 4'b0001;
            else if (spr_valid && read_ok) grant = 4'b0010;
            else if (!rr_cmd && cpu_ok)    grant = 4'b0100;
            else if (cmd_ok)               grant = 4'b1000;
            else if (cpu_ok)               grant = 4'b0100;
        end
    end

    always_comb begin
        sel_id    = 2'd0;
        sel_addr  = dsp_address;
        sel_write = 1'b0;
        sel_wdata = cpu_wdata;
        if (grant[1]) begin
            sel_id   = 2'd1;
            sel_addr = spr_address;
        end else if (grant[2]) begin
            sel_id    = 2'd2;
            sel_addr  = cpu_address;
            sel_write = cpu_write;
        end else if (grant[3]) begin
            sel_id    = 2'd3;
            sel_addr  = cmd_address;
            sel_write = cmd_write;
            sel_wdata = cmd_wdata;
        end
    end

    assign dsp_ready = grant[0];
    assign spr_ready = grant[1];
    assign cpu_ready = grant[2];
    assign cmd_ready = grant[3];

    assign push = (|grant) && !sel_write;
    assign pop  = vram_rdata_en && (tag_count != '0);
    assign head = tag_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= {sel_id, sel_addr[1:0]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vram_valid      <= 1'b0;
            vram_address    <= '0;
            vram_write      <= 1'b0;
            vram_wdata      <= '0;
            vram_wdata_mask <= '0;
            rr_cmd          <= 1'b0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            tag_count       <= '0;
            tag_underflow   <= 1'b0;
            dsp_rdata_en    <= 1'b0;
            spr_rdata_en    <= 1'b0;
            cpu_rdata_en    <= 1'b0;
            cmd_rdata_en    <= 1'b0;
            dsp_rdata       <= '0;
            spr_rdata       <= '0;
            cpu_rdata       <= '0;
            cmd_rdata       <= '0;
        end else begin
            if (|grant) begin
                vram_valid <= 1'b1;
                vram_write <= sel_write;
                if (sel_write) begin
                    vram_address    <= sel_addr;
                    vram_wdata      <= {4{sel_wdata}};
                    vram_wdata_mask <= 4'b0001 << sel_addr[1:0];
                end else begin
                    vram_address    <= {sel_addr[16:2], 2'b00};
                    vram_wdata      <= '0;
                    vram_wdata_mask <= 4'b0000;
                end
            end else if (vram_ready) begin
                vram_valid <= 1'b0;
            end

            if (grant[2])      rr_cmd <= 1'b1;
            else if (grant[3]) rr_cmd <= 1'b0;

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            tag_count <= tag_count + CW'(push) - CW'(pop);

            if (vram_rdata_en && tag_count == '0) tag_underflow <= 1'b1;

            dsp_rdata_en <= 1'b0;
            spr_rdata_en <= 1'b0;
            cpu_rdata_en <= 1'b0;
            cmd_rdata_en <= 1'b0;
            if (pop) begin
                case (head[3:2])
                    2'd0: begin dsp_rdata_en <= 1'b1; dsp_rdata <= vram_rdata; end
                    2'd1: begin spr_rdata_en <= 1'b1; spr_rdata <= vram_rdata; end
                    2'd2: begin cpu_rdata_en <= 1'b1; cpu_rdata <= vram_rdata[{head[1:0], 3'b000} +: 8]; end
                    default: begin cmd_rdata_en <= 1'b1; cmd_rdata <= vram_rdata; end
                endcase
            end
        end
    end
endmodule
